run_dump_ctrl: RTL and testbench
================================

RUN_DUMP_CTRL -- requirements
Module: run_dump_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREGS, default 32, register-file depth; legal range 2 or more.
REQ-003 SHALL have parameter FIRST_REG, default 1, first register index dumped; legal range below NREGS.
REQ-004 SHALL have parameter CW, default 16, cycle-counter width; AW = clog2(NREGS) is derived.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  run request, sampled only in IDLE.
REQ-008 SHALL have port run_cycles  in  CW  number of processor cycles to execute, latched on accepted start.
REQ-009 SHALL have port halt_req  in  1  processor halt indication (e.g. ebreak decoded).
REQ-010 SHALL have port cpu_rst  out  1  active-high reset to processor.
REQ-011 SHALL have port cpu_en  out  1  processor advance enable (PC/RF write gate).
REQ-012 SHALL have port rf_raddr  out  AW  register-file read address.
REQ-013 SHALL have port rf_rdata  in  XLEN  register-file asynchronous read data.
REQ-014 SHALL have ports dump_valid out 1, dump_ready in 1, dump_idx out AW, dump_data out XLEN  register dump stream.
REQ-015 SHALL have ports cycles_run out CW, halted out 1, busy out 1, done out 1  status.

Function
REQ-016 SHALL implement FSM states IDLE, RESET, RUN, DUMP, DONE.
REQ-017 IDLE: start=1 SHALL latch run_cycles, clear cycles_run and halted, go to RESET; otherwise stay.
REQ-018 RESET: cpu_rst=1, cpu_en=0 for exactly one cycle; next state RUN if latched limit > 0, else DUMP.
REQ-019 RUN: cpu_en=1 when halt_req=0; cycles_run increments by 1 each enabled cycle.
REQ-020 RUN: on the enabled cycle where cycles_run+1 equals the limit, next state SHALL be DUMP (exactly limit enabled cycles).
REQ-021 RUN: halt_req=1 SHALL force cpu_en=0 that cycle, not count it, set halted=1, go to DUMP; halt takes priority over limit.
REQ-022 DUMP entry: index register SHALL equal FIRST_REG; cpu_en=0 throughout DUMP.
REQ-023 DUMP: dump_valid=1, rf_raddr=dump_idx=index, dump_data=rf_rdata.
REQ-024 Transfer occurs on dump_valid and dump_ready both high; index then increments by 1.
REQ-025 While dump_valid=1 and dump_ready=0, dump_idx and dump_data SHALL remain stable; no index skipped or repeated.
REQ-026 Transfer of index NREGS-1 SHALL move to DONE; no wrap-around to 0.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; start in DONE is ignored.
REQ-028 busy=1 in RESET, RUN, DUMP, DONE; start while busy SHALL be ignored, latched limit unchanged.
REQ-029 cycles_run and halted SHALL hold their final values in IDLE until the next accepted start.
REQ-030 Outside DUMP, dump_valid=0; rf_raddr=index register (don't-care to consumer).
REQ-031 cycles_run never exceeds the latched limit; no counter overflow is possible.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, cycles_run=0, halted=0, done=0, busy=0, dump_valid=0, cpu_en=0, index=FIRST_REG.
REQ-033 cpu_rst SHALL be 1 combinationally while rst=0, and 0 in IDLE after reset release.
REQ-034 Reset asserted mid-RUN or mid-DUMP SHALL abort the operation with no further dump beats or done pulse.

Verification
REQ-035 start, run_cycles=10, dump_ready=1 -> cpu_rst one cycle, cpu_en high exactly 10 cycles, cycles_run=10, halted=0, 31 beats idx 1..31 with data equal to RF contents, done one cycle after last beat.
REQ-036 run_cycles=20, halt_req raised on 4th RUN cycle -> cpu_en high 3 cycles, cycles_run=3, halted=1, full dump follows.
REQ-037 run_cycles=0 -> cpu_en never high, DUMP directly after RESET, cycles_run=0.
REQ-038 dump_ready random 50% -> valid held under stall, dump_idx/data stable, each idx 1..31 seen exactly once in order.
REQ-039 start pulsed during RUN with different run_cycles -> ignored, original limit honoured.
REQ-040 rst low during DUMP at idx 7 -> IDLE, dump_valid=0, cycles_run=0, cpu_rst=1 while low, no done pulse.

Source files
------------

// File: rtl/run_dump_ctrl.sv
// run_dump_ctrl: resets and runs a processor for a bounded cycle count, then streams out its register file.
module run_dump_ctrl #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int FIRST_REG = 1,
  parameter int CW        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CW-1:0]              run_cycles,
  input  logic                       halt_req,
  output logic                       cpu_rst,
  output logic                       cpu_en,
  output logic [$clog2(NREGS)-1:0]   rf_raddr,
  input  logic [XLEN-1:0]            rf_rdata,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [$clog2(NREGS)-1:0]   dump_idx,
  output logic [XLEN-1:0]            dump_data,
  output logic [CW-1:0]              cycles_run,
  output logic                       halted,
  output logic                       busy,
  output logic                       done
);
  localparam int AW = $clog2(NREGS);
  typedef enum logic [2:0] {IDLE, RESET, RUN, DUMP, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] limit;
  logic [AW-1:0] idx;
  logic xfer, last;
  assign xfer       = (state == DUMP) && dump_ready;
  assign last       = idx == AW'(NREGS - 1);
  assign cpu_rst    = ~rst | (state == RESET);
  assign cpu_en     = (state == RUN) && !halt_req;
  assign dump_valid = state == DUMP;
  assign rf_raddr   = idx;
  assign dump_idx   = idx;
  assign dump_data  = rf_rdata;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? RESET : IDLE;
      RESET:   nxt = (limit != '0) ? RUN : DUMP;
      RUN:     nxt = (halt_req || cycles_run + CW'(1) == limit) ? DUMP : RUN;
      DUMP:    nxt = (xfer && last) ? DONE : DUMP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      limit      <= '0;
      cycles_run <= '0;
      halted     <= 1'b0;
      idx        <= AW'(FIRST_REG);
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        limit      <= run_cycles;
        cycles_run <= '0;
        halted     <= 1'b0;
      end
      if (state == RUN && halt_req)
        halted <= 1'b1;
      else if (state == RUN)
        cycles_run <= cycles_run + CW'(1);
      // index parks at FIRST_REG outside DUMP so every dump starts there
      idx <= (state != DUMP || (xfer && last)) ? AW'(FIRST_REG) : idx + AW'(xfer);
    end
  end
endmodule

// File: tb/tb_run_dump_ctrl.sv
// tb_run_dump_ctrl: directed checks of run/halt/dump sequencing against a behavioural register file.
module tb_run_dump_ctrl;
  logic        clk = 0, rst = 0, start = 0, halt_req = 0, dump_ready = 0;
  logic [15:0] run_cycles = '0;
  logic        cpu_rst, cpu_en, dump_valid, halted, busy, done;
  logic [4:0]  rf_raddr, dump_idx;
  logic [31:0] rf_rdata, dump_data;
  logic [15:0] cycles_run;
  logic [31:0] rf [32];
  int n_checks = 0, n_err = 0;
  int en_total = 0, done_total = 0;

  run_dump_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .run_cycles(run_cycles), .halt_req(halt_req),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .cycles_run(cycles_run), .halted(halted), .busy(busy), .done(done)
  );

  assign rf_rdata = rf[rf_raddr];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (cpu_en) en_total <= en_total + 1;
    if (done) done_total <= done_total + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input logic [15:0] lim, input int halt_at, input int poke_at,
                        input bit rnd, input int exp_cyc, input bit exp_halt);
    int en0, d0, k, e, c;
    en0 = en_total;
    start = 1; run_cycles = lim;
    step();
    start = 0;
    chk("reset_cpu_rst", cpu_rst, 1);
    chk("reset_cpu_en", cpu_en, 0);
    chk("reset_busy", busy, 1);
    chk("reset_cycles_cleared", cycles_run, 0);
    k = 0;
    step();
    while (!dump_valid && k < 300) begin
      k++;
      halt_req = (k == halt_at);
      start = (k == poke_at);
      run_cycles = start ? 16'd3 : lim;
      #1 chk("run_cpu_en", cpu_en, (k != halt_at));
      chk("run_cpu_rst", cpu_rst, 0);
      step();
    end
    halt_req = 0; start = 0;
    chk("en_cycles", en_total - en0, exp_cyc);
    chk("cycles_run", cycles_run, exp_cyc);
    chk("halted", halted, exp_halt);
    e = 1; c = 0;
    while (e < 32 && c < 400) begin
      c++;
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1 chk("dump_valid", dump_valid, 1);
      chk("dump_idx", dump_idx, e);
      chk("dump_data", dump_data, rf[e]);
      chk("dump_cpu_en", cpu_en, 0);
      step();
      if (dump_ready) e++;
    end
    dump_ready = 0;
    chk("dump_count", e, 32);
    d0 = done_total;
    chk("done_pulse", done, 1);
    chk("done_valid_low", dump_valid, 0);
    step();
    chk("done_once", done_total - d0, 1);
    chk("idle_done_low", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_cycles", cycles_run, exp_cyc);
    chk("hold_halted", halted, exp_halt);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
    #2;
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_cycles", cycles_run, 0);
    chk("rst_cpu_en", cpu_en, 0);
    step();
    rst = 1;
    step();
    chk("idle_cpu_rst", cpu_rst, 0);
    chk("idle_busy0", busy, 0);
    do_run(16'd10, 0, 0, 0, 10, 0);
    do_run(16'd20, 4, 0, 0, 3, 1);
    do_run(16'd0, 0, 0, 0, 0, 0);
    do_run(16'd5, 0, 0, 1, 5, 0);
    do_run(16'd10, 0, 2, 0, 10, 0);
    start = 1; run_cycles = 16'd2;
    step();
    start = 0;
    for (int i = 0; i < 20 && !dump_valid; i++) step();
    dump_ready = 1;
    for (int i = 0; i < 40 && dump_idx != 5'd7; i++) step();
    chk("abort_at_idx7", dump_idx, 7);
    d0 = done_total;
    rst = 0;
    #1;
    chk("abort_valid", dump_valid, 0);
    chk("abort_cpu_rst", cpu_rst, 1);
    chk("abort_busy", busy, 0);
    chk("abort_cycles", cycles_run, 0);
    step(); step();
    chk("abort_cpu_rst_held", cpu_rst, 1);
    rst = 1;
    step();
    chk("abort_release_cpu_rst", cpu_rst, 0);
    for (int i = 0; i < 5; i++) step();
    dump_ready = 0;
    chk("abort_no_done", done_total - d0, 0);
    chk("abort_idle_valid", dump_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
